rom_read_arbiter: RTL and testbench

Shares the single asynchronous, byte-addressed boot ROM read port between the instruction-fetch requester (IF) and the load requester (LS). The ROM occupies the 4 KB window 0xBFC00000–0xBFC00FFF. Each requester uses a req/gnt handshake and receives a registered response one cycle after its grant. Out-of-window and misaligned accesses are rejected with an error response instead of aliasing into the ROM.

---
 rtl/rom_read_arbiter_if.sv | 50 +++++
 rtl/rom_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rom_read_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter_if
//
// Purpose : Bundles the two requester handshakes (IF and LS) and the shared
//           boot-ROM read port that the arbiter drives.
//
// Signals : if_req / ls_req       requester asks for a read (held until gnt)
//           if_addr / ls_addr     requester byte address
//           if_gnt / ls_gnt       request accepted this cycle (combinational)
//           if_rvalid / ls_rvalid one-cycle response pulse, one cycle after gnt
//           if_rdata / ls_rdata   response word (holds between responses)
//           if_err / ls_err       response is an error (qualified by rvalid)
//           rom_addr              byte offset presented to the ROM
//           rom_dout              asynchronous ROM word at rom_addr
//
// Modports: master - requester/ROM environment side
//           slave  - arbiter side
// ---------------------------------------------------------------------------
interface rom_read_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  ls_req;
  logic [DATA_WIDTH-1:0] ls_addr;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_err;

  logic [DATA_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_dout;

  modport master (
    output if_req, if_addr, ls_req, ls_addr, rom_dout,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, rom_dout,
    output if_gnt, if_rvalid, if_rdata, if_err,
           ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
//
// Purpose : Shares the single asynchronous boot-ROM read port between the
//           instruction-fetch (IF) and load (LS) requesters. One grant per
//           cycle; the granted address is checked against the 4 KB ROM window
//           and word alignment, and the response (data or error) is
//           registered one cycle after the grant.
//
// Ports   : clk  - single clock, rising edge
//           rst  - synchronous, active-high reset
//           bus  - rom_read_arbiter_if.slave (IF/LS handshakes + ROM port)
//
// Config  : ROM_ARB_FIXED_PRIO_EN
//             defined   -> fixed priority, LS always beats IF (IF may starve)
//             undefined -> round-robin on a 1-bit last-grant register
// ---------------------------------------------------------------------------
module rom_read_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000
) (
  input  logic               clk,
  input  logic               rst,
  rom_read_arbiter_if.slave  bus
);

  // Upper address bits that identify the ROM window.
  localparam logic [DATA_WIDTH-ADDR_WIDTH-1:0] ROM_TAG =
    BASE_ADDR[DATA_WIDTH-1:ADDR_WIDTH];

  // ------------------------------------------------------------------------
  // Input aliases
  // ------------------------------------------------------------------------
  logic                  w_if_req;
  logic                  w_ls_req;
  logic [DATA_WIDTH-1:0] w_if_addr;
  logic [DATA_WIDTH-1:0] w_ls_addr;
  logic [DATA_WIDTH-1:0] w_rom_dout;

  assign w_if_req   = bus.if_req;
  assign w_ls_req   = bus.ls_req;
  assign w_if_addr  = bus.if_addr;
  assign w_ls_addr  = bus.ls_addr;
  assign w_rom_dout = bus.rom_dout;

  // ------------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------------
  logic w_if_gnt;
  logic w_ls_gnt;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // LS always wins; no history is kept.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (!rst) begin
      w_ls_gnt = w_ls_req;
      w_if_gnt = w_if_req && !w_ls_req;
    end
  end
`else
  typedef enum logic {
    SIDE_IF = 1'b0,
    SIDE_LS = 1'b1
  } side_e;

  side_e r_last_grant;
  side_e w_last_grant_next;

  // Under contention the side that did not win last time gets the grant,
  // so each requester waits at most one cycle.
  always_comb begin
    w_if_gnt          = 1'b0;
    w_ls_gnt          = 1'b0;
    w_last_grant_next = r_last_grant;
    if (!rst) begin
      if (w_if_req && w_ls_req) begin
        w_if_gnt = (r_last_grant == SIDE_LS);
        w_ls_gnt = (r_last_grant == SIDE_IF);
      end else begin
        w_if_gnt = w_if_req;
        w_ls_gnt = w_ls_req;
      end
      if (w_if_gnt) begin
        w_last_grant_next = SIDE_IF;
      end else if (w_ls_gnt) begin
        w_last_grant_next = SIDE_LS;
      end
    end
  end

  // Reset to LS so that IF wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= SIDE_LS;
    end else begin
      r_last_grant <= w_last_grant_next;
    end
  end
`endif

  // ------------------------------------------------------------------------
  // Address check on the granted address
  // ------------------------------------------------------------------------
  logic                  w_any_gnt;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic                  w_in_range;
  logic                  w_aligned;
  logic                  w_ok;
  logic [DATA_WIDTH-1:0] w_rom_addr;
  logic [DATA_WIDTH-1:0] w_resp_data;

  assign w_any_gnt  = w_if_gnt | w_ls_gnt;
  assign w_sel_addr = w_ls_gnt ? w_ls_addr : w_if_addr;
  assign w_in_range = (w_sel_addr[DATA_WIDTH-1:ADDR_WIDTH] == ROM_TAG);
  // Alignment check also rejects the top three bytes of the window, so an
  // access there never wraps back to offset 0.
  assign w_aligned  = (w_sel_addr[1:0] == 2'b00);
  assign w_ok       = w_in_range && w_aligned;

  // The ROM only sees an offset for a legal granted access; anything else
  // parks the port at offset 0.
  always_comb begin
    w_rom_addr = '0;
    if (w_any_gnt && w_ok) begin
      w_rom_addr = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_sel_addr[ADDR_WIDTH-1:0]};
    end
  end

  assign w_resp_data = w_ok ? w_rom_dout : '0;

  // ------------------------------------------------------------------------
  // Response registers
  // ------------------------------------------------------------------------
  logic                  r_if_rvalid;
  logic                  r_if_err;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic                  r_ls_rvalid;
  logic                  r_ls_err;
  logic [DATA_WIDTH-1:0] r_ls_rdata;

  // A reset on the edge after a grant drops that response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_if_gnt;
      r_if_err    <= w_if_gnt && !w_ok;
      r_ls_rvalid <= w_ls_gnt;
      r_ls_err    <= w_ls_gnt && !w_ok;
      // rdata holds between responses.
      if (w_if_gnt) begin
        r_if_rdata <= w_resp_data;
      end
      if (w_ls_gnt) begin
        r_ls_rdata <= w_resp_data;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.rom_addr  = w_rom_addr;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_err    = r_if_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_err    = r_ls_err;
  assign bus.ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Purpose : Directed self-checking bench for rom_read_arbiter. The ROM is a
//           combinational stand-in returning 0xCAFE0000 | word_index, so the
//           word at offset 4 is 0xCAFE0001 and at offset 0xFFC 0xCAFE03FF.
//           Inputs change and outputs are checked around the falling edge.
// ---------------------------------------------------------------------------
module tb_rom_read_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rom_read_arbiter_if #(.DATA_WIDTH(32)) bus ();

  rom_read_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(12),
    .BASE_ADDR (32'hBFC00000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ROM stand-in: only offsets inside the 4 KB window return ROM content.
  assign bus.rom_dout = (bus.rom_addr[31:12] == 20'd0)
                      ? (32'hCAFE0000 | {22'd0, bus.rom_addr[11:2]})
                      : 32'hDEADBEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  task automatic test_reset;
    rst         = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hBFC00004;
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'hBFC00010;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt: got %b expected 0", bus.if_gnt); end
    checks++; if (bus.ls_gnt !== 1'b0) begin errors++; $display("FAIL reset_ls_gnt: got %b expected 0", bus.ls_gnt); end
    checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 00000000", bus.rom_addr); end
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid: got %b expected 0", bus.if_rvalid); end
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ls_rvalid: got %b expected 0", bus.ls_rvalid); end
    checks++; if (bus.if_err !== 1'b0) begin errors++; $display("FAIL reset_if_err: got %b expected 0", bus.if_err); end
    checks++; if (bus.ls_err !== 1'b0) begin errors++; $display("FAIL reset_ls_err: got %b expected 0", bus.ls_err); end
    checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h expected 00000000", bus.if_rdata); end
    checks++; if (bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL reset_ls_rdata: got %h expected 00000000", bus.ls_rdata); end
    $display("txn reset: outputs idle while rst high");
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_if;
    @(negedge clk);
    rst         = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hBFC00004;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL single_if_gnt: got %b expected 1", bus.if_gnt); end
    checks++; if (bus.ls_gnt !== 1'b0) begin errors++; $display("FAIL single_ls_gnt: got %b expected 0", bus.ls_gnt); end
    checks++; if (bus.rom_addr !== 32'h4) begin errors++; $display("FAIL single_rom_addr: got %h expected 00000004", bus.rom_addr); end
    @(negedge clk);
    bus.if_req = 1'b0;
    #1;
    checks++; if (bus.if_rvalid !== 1'b1) begin errors++; $display("FAIL single_if_rvalid: got %b expected 1", bus.if_rvalid); end
    checks++; if (bus.if_err !== 1'b0) begin errors++; $display("FAIL single_if_err: got %b expected 0", bus.if_err); end
    checks++; if (bus.if_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_if_rdata: got %h expected cafe0001", bus.if_rdata); end
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL single_ls_rvalid: got %b expected 0", bus.ls_rvalid); end
    $display("txn if_read addr=bfc00004 rdata=%h err=%b", bus.if_rdata, bus.if_err);
    @(negedge clk);
    #1;
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL single_if_rvalid_pulse: got %b expected 0", bus.if_rvalid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_contention;
    logic [3:0] exp_if;
    logic [3:0] exp_ls;
    logic [31:0] exp_rom;
`ifdef ROM_ARB_FIXED_PRIO_EN
    exp_if = 4'b0000;
    exp_ls = 4'b1111;
`else
    exp_if = 4'b0101;   // bit i = grant in cycle i: IF, LS, IF, LS
    exp_ls = 4'b1010;
`endif
    // Fresh reset so last_grant starts at LS.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'hBFC00000;
      bus.ls_req  = 1'b1;
      bus.ls_addr = 32'hBFC00010;
      #1;
      exp_rom = exp_if[i] ? 32'h0 : 32'h10;
      checks++; if (bus.if_gnt !== exp_if[i]) begin errors++; $display("FAIL cont_if_gnt[%0d]: got %b expected %b", i, bus.if_gnt, exp_if[i]); end
      checks++; if (bus.ls_gnt !== exp_ls[i]) begin errors++; $display("FAIL cont_ls_gnt[%0d]: got %b expected %b", i, bus.ls_gnt, exp_ls[i]); end
      checks++; if (bus.rom_addr !== exp_rom) begin errors++; $display("FAIL cont_rom_addr[%0d]: got %h expected %h", i, bus.rom_addr, exp_rom); end
      if (i != 0) begin
        checks++; if (bus.if_rvalid !== exp_if[i-1]) begin errors++; $display("FAIL cont_if_rvalid[%0d]: got %b expected %b", i, bus.if_rvalid, exp_if[i-1]); end
        checks++; if (bus.ls_rvalid !== exp_ls[i-1]) begin errors++; $display("FAIL cont_ls_rvalid[%0d]: got %b expected %b", i, bus.ls_rvalid, exp_ls[i-1]); end
      end
      $display("txn contention cycle=%0d if_gnt=%b ls_gnt=%b", i, bus.if_gnt, bus.ls_gnt);
    end
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    checks++; if (bus.if_rvalid !== exp_if[3]) begin errors++; $display("FAIL cont_if_rvalid[4]: got %b expected %b", bus.if_rvalid, exp_if[3]); end
    checks++; if (bus.ls_rvalid !== exp_ls[3]) begin errors++; $display("FAIL cont_ls_rvalid[4]: got %b expected %b", bus.ls_rvalid, exp_ls[3]); end
    checks++; if (bus.ls_rdata !== 32'hCAFE0004) begin errors++; $display("FAIL cont_ls_rdata: got %h expected cafe0004", bus.ls_rdata); end
    checks++; if (bus.ls_err !== 1'b0) begin errors++; $display("FAIL cont_ls_err: got %b expected 0", bus.ls_err); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_out_of_range;
    @(negedge clk);
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'hBFC01000;
    #1;
    checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL oor_ls_gnt: got %b expected 1", bus.ls_gnt); end
    checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL oor_rom_addr: got %h expected 00000000", bus.rom_addr); end
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1;
    checks++; if (bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL oor_ls_rvalid: got %b expected 1", bus.ls_rvalid); end
    checks++; if (bus.ls_err !== 1'b1) begin errors++; $display("FAIL oor_ls_err: got %b expected 1", bus.ls_err); end
    checks++; if (bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL oor_ls_rdata: got %h expected 00000000", bus.ls_rdata); end
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL oor_if_rvalid: got %b expected 0", bus.if_rvalid); end
    $display("txn ls_read addr=bfc01000 rdata=%h err=%b", bus.ls_rdata, bus.ls_err);
  endtask

  // -------------------------------------------------------------------------
  // Misaligned top byte then last legal word, back to back on LS.
  task automatic test_back_to_back;
    @(negedge clk);
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'hBFC00FFD;
    #1;
    checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b expected 1", bus.ls_gnt); end
    checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL b2b_rom_addr0: got %h expected 00000000", bus.rom_addr); end
    @(negedge clk);
    bus.ls_addr = 32'hBFC00FFC;
    #1;
    checks++; if (bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid0: got %b expected 1", bus.ls_rvalid); end
    checks++; if (bus.ls_err !== 1'b1) begin errors++; $display("FAIL b2b_err0: got %b expected 1", bus.ls_err); end
    checks++; if (bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rdata0: got %h expected 00000000", bus.ls_rdata); end
    checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt1: got %b expected 1", bus.ls_gnt); end
    checks++; if (bus.rom_addr !== 32'hFFC) begin errors++; $display("FAIL b2b_rom_addr1: got %h expected 00000ffc", bus.rom_addr); end
    $display("txn ls_read addr=bfc00ffd rdata=%h err=%b", bus.ls_rdata, bus.ls_err);
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1;
    checks++; if (bus.ls_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid1: got %b expected 1", bus.ls_rvalid); end
    checks++; if (bus.ls_err !== 1'b0) begin errors++; $display("FAIL b2b_err1: got %b expected 0", bus.ls_err); end
    checks++; if (bus.ls_rdata !== 32'hCAFE03FF) begin errors++; $display("FAIL b2b_rdata1: got %h expected cafe03ff", bus.ls_rdata); end
    $display("txn ls_read addr=bfc00ffc rdata=%h err=%b", bus.ls_rdata, bus.ls_err);
    @(negedge clk);
    #1;
    checks++; if (bus.ls_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle_rvalid: got %b expected 0", bus.ls_rvalid); end
    checks++; if (bus.ls_rdata !== 32'hCAFE03FF) begin errors++; $display("FAIL b2b_rdata_hold: got %h expected cafe03ff", bus.ls_rdata); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hBFC00008;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL mid_if_gnt: got %b expected 1", bus.if_gnt); end
    #2;
    rst = 1'b1;     // lands before the edge that would capture the response
    @(negedge clk);
    #1;
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL mid_if_rvalid: got %b expected 0", bus.if_rvalid); end
    checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL mid_if_rdata: got %h expected 00000000", bus.if_rdata); end
    checks++; if (bus.if_gnt !== 1'b0) begin errors++; $display("FAIL mid_if_gnt_in_rst: got %b expected 0", bus.if_gnt); end
    $display("txn if_read addr=bfc00008 dropped by reset");
    @(negedge clk);
    rst         = 1'b0;
    bus.if_addr = 32'hBFC00000;
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'hBFC00010;
    #1;
`ifdef ROM_ARB_FIXED_PRIO_EN
    checks++; if (bus.ls_gnt !== 1'b1) begin errors++; $display("FAIL mid_post_ls_gnt: got %b expected 1", bus.ls_gnt); end
    checks++; if (bus.if_gnt !== 1'b0) begin errors++; $display("FAIL mid_post_if_gnt: got %b expected 0", bus.if_gnt); end
`else
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL mid_post_if_gnt: got %b expected 1", bus.if_gnt); end
    checks++; if (bus.ls_gnt !== 1'b0) begin errors++; $display("FAIL mid_post_ls_gnt: got %b expected 0", bus.ls_gnt); end
`endif
    $display("txn contention after reset if_gnt=%b ls_gnt=%b", bus.if_gnt, bus.ls_gnt);
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
`ifdef ROM_ARB_FIXED_PRIO_EN
    checks++; if (bus.ls_rdata !== 32'hCAFE0004) begin errors++; $display("FAIL mid_post_ls_rdata: got %h expected cafe0004", bus.ls_rdata); end
`else
    checks++; if (bus.if_rdata !== 32'hCAFE0000) begin errors++; $display("FAIL mid_post_if_rdata: got %h expected cafe0000", bus.if_rdata); end
`endif
  endtask

  // -------------------------------------------------------------------------
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.ls_req  = 1'b0;
    bus.ls_addr = 32'h0;

    test_reset();
    test_single_if();
    test_contention();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
